lsu_align: RTL and testbench
============================

Name: lsu_align

Overview:
- Load/store unit directly upstream of the data memory.
- Takes one load/store request from the execute stage and converts it into word-granular memory accesses with byte enables.
- Sign- or zero-extends load data, handles misaligned accesses, and returns one response per request.
- Replaces ad-hoc byte masking inside the memory: the memory only sees word address, write data and byte enables.

Parameters:
- MEM_AW, 11, word-address width of the data memory (word address = byte address[MEM_AW+1:2]).
- XLEN, 32, data width; fixed at 32 (not verified for other values).

Ports:
- CLK  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU are loads only).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  valid with resp_valid; illegal funct3 or disallowed misalignment.
- mem_re  out  1  memory read strobe.
- mem_we  out  1  memory write strobe.
- mem_addr  out  MEM_AW  word address.
- mem_be  out  4  byte enables; bit i = byte lane i.
- mem_wdata  out  32  lane-aligned write data.
- mem_rdata  in  32  read data, valid in the cycle after mem_re.

Behaviour:
- States: IDLE, ACC0, ACC1, CAP, RESP. Request accepted on a rising edge with req_valid && req_ready; fields latched on acceptance.
- Reset (async): state=IDLE; resp_valid=0, resp_rdata=0, resp_err=0, mem_re=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0. A reset mid-operation aborts the request with no response; a partial split store may have written its first word.
- Decode at acceptance:
  - off = addr[1:0]; size = 1/2/4 bytes.
  - split = off+size > 4.
  - Illegal: funct3 not in the set, or store with 100/101.
  - Misaligned: H with off[0]=1, or W with off!=0.
- Illegal, or misaligned while the feature is disabled: IDLE->RESP, resp_err=1, no memory strobes.
- ACC0:
  - Load: mem_re=1 at word addr[MEM_AW+1:2].
  - Store: mem_we=1, mem_be = ((1<<size)-1)<<off truncated to 4 bits, mem_wdata = wdata<<(8*off).
  - Exit: ACC1 if split; else CAP for loads, RESP for stores.
- ACC1 (split only):
  - Word address +1, wrapping modulo 2^MEM_AW.
  - Load: mem_re=1; mem_rdata (word0) captured at end of cycle.
  - Store: mem_we=1, mem_be = ((1<<size)-1)>>(4-off), mem_wdata = wdata>>(8*(4-off)).
  - Exit: CAP for loads, RESP for stores.
- CAP: mem_rdata (last word) captured. Raw value = {word1,word0}>>(8*off) for split, word0>>(8*off) otherwise, truncated to size, then extended: B/H sign-extend, BU/HU/W zero-extend. The registered result is presented in RESP.
- RESP: resp_valid=1 for exactly one cycle, no backpressure; then IDLE. resp_rdata and resp_err are held until the next response.
- Strobes are low in every state not listed above. mem_re and mem_we are never high together.
- Latency, counting the acceptance edge as 0 and giving the cycle of resp_valid:
  - Aligned load: 3.
  - Split load: 4.
  - Aligned store: 2.
  - Split store: 3.
  - Error: 1.

Optional Feature:
- Macro LSU_MISALIGN_SPLIT_EN.
- Defined:
  - Misaligned accesses are performed.
  - Non-crossing accesses (e.g. H at off=1) use a single access with shifted enables.
  - Crossing accesses use ACC0+ACC1.
- Undefined:
  - Any misaligned access returns resp_err=1, resp_rdata=0, with no memory strobes.
  - ACC1 is unreachable.
- Legal aligned behaviour is identical in both builds.

Test Plan:
- LB addr=0x102, mem word 0x40=0x0080_0000 -> one read at word 0x40, resp_valid in cycle 3, resp_rdata=0xFFFF_FF80, resp_err=0.
- LHU addr=0x6, mem word 1=0xBEEF_1234 -> resp_rdata=0x0000_BEEF; the same access as LH -> 0xFFFF_BEEF.
- SW addr=0x7, wdata=0xAABB_CCDD, feature on -> cycle 1: addr 1, be=1000, wdata=0xDD00_0000; cycle 2: addr 2, be=0111, wdata=0x00AA_BBCC; resp_valid in cycle 3. Feature off -> resp_err=1 in cycle 1, no mem_we.
- LW addr=0x1FFF (last word, offset 3), MEM_AW=11, mem[0x7FF]=0x11xx_xxxx, mem[0]=0x0044_3322 -> second read at word 0 (wrap), resp_rdata=0x4433_2211 in cycle 4.
- Store with funct3=100 and load with funct3=011 -> resp_err=1 one cycle after acceptance; no strobes; resp_rdata=0.
- Assert reset in ACC1 of a split load -> mem_re drops immediately; no resp_valid; req_ready=1 after release; a following aligned SB completes normally.

Source files
------------

// File: rtl/lsu_align.sv
`timescale 1ns/1ps
// lsu_align: converts byte-addressed load/store requests into word accesses with
// byte enables and extends load data. Misaligned support: define LSU_MISALIGN_SPLIT_EN.
module lsu_align #(
   parameter int MEM_AW = 11,
   parameter int XLEN   = 32
) (
   input  logic              CLK,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [XLEN-1:0]   req_addr,
   input  logic [XLEN-1:0]   req_wdata,
   output logic              resp_valid,
   output logic [XLEN-1:0]   resp_rdata,
   output logic              resp_err,
   output logic              mem_re,
   output logic              mem_we,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [3:0]        mem_be,
   output logic [XLEN-1:0]   mem_wdata,
   input  logic [XLEN-1:0]   mem_rdata
);

   typedef enum logic [2:0] {IDLE, ACC0, ACC1, CAP, RESP} state_t;

   state_t              r_state;
   state_t              w_next;

   logic                r_we;
   logic [2:0]          r_f3;
   logic [1:0]          r_off;
   logic                r_split;
   logic [MEM_AW-1:0]   r_waddr;
   logic [XLEN-1:0]     r_wdata;
   logic [XLEN-1:0]     r_word0;
   logic [XLEN-1:0]     r_rdata;
   logic                r_err;

   logic                w_accept;
   logic [1:0]          w_off;
   logic [2:0]          w_size;
   logic                w_illegal;
   logic                w_misal;
   logic                w_split;
   logic                w_err;
   logic [3:0]          w_szmask;
   logic [7:0]          w_mask8;
   logic [2*XLEN-1:0]   w_wdata64;
   logic [2*XLEN-1:0]   w_rd64;
   logic [2*XLEN-1:0]   w_shift64;
   logic [XLEN-1:0]     w_raw;
   logic [XLEN-1:0]     w_ext;
   logic                w_unused;

   assign w_accept = req_valid && (r_state == IDLE);
   assign w_off    = req_addr[1:0];

   always_comb begin
      w_size = 3'd0;
      case (req_funct3[1:0])
         2'b00:   w_size = 3'd1;
         2'b01:   w_size = 3'd2;
         2'b10:   w_size = 3'd4;
         default: w_size = 3'd0;
      endcase
      w_illegal = (req_funct3[1:0] == 2'b11) || (req_funct3 == 3'b110) ||
                  (req_we && req_funct3[2]);
      w_misal   = ((req_funct3[1:0] == 2'b01) && w_off[0]) ||
                  ((req_funct3[1:0] == 2'b10) && (w_off != 2'b00));
      w_split   = ({2'b00, w_off} + {1'b0, w_size}) > 4'd4;
   end

`ifdef LSU_MISALIGN_SPLIT_EN
   assign w_err = w_illegal;
`else
   assign w_err = w_illegal || w_misal;
`endif

   // Lane placement: low half of the 8-lane window goes to word0, high half to word1.
   always_comb begin
      w_szmask = 4'b0000;
      case (r_f3[1:0])
         2'b00:   w_szmask = 4'b0001;
         2'b01:   w_szmask = 4'b0011;
         2'b10:   w_szmask = 4'b1111;
         default: w_szmask = 4'b0000;
      endcase
   end

   assign w_mask8   = {4'b0000, w_szmask} << r_off;
   assign w_wdata64 = {{XLEN{1'b0}}, r_wdata} << {r_off, 3'b000};

   assign w_rd64    = r_split ? {mem_rdata, r_word0} : {{XLEN{1'b0}}, mem_rdata};
   assign w_shift64 = w_rd64 >> {r_off, 3'b000};
   assign w_raw     = w_shift64[XLEN-1:0];

   always_comb begin
      w_ext = w_raw;
      case (r_f3)
         3'b000:  w_ext = {{(XLEN-8){w_raw[7]}}, w_raw[7:0]};
         3'b001:  w_ext = {{(XLEN-16){w_raw[15]}}, w_raw[15:0]};
         3'b100:  w_ext = {{(XLEN-8){1'b0}}, w_raw[7:0]};
         3'b101:  w_ext = {{(XLEN-16){1'b0}}, w_raw[15:0]};
         default: w_ext = w_raw;
      endcase
   end

   assign w_unused = ^{req_addr[XLEN-1:MEM_AW+2], w_shift64[2*XLEN-1:XLEN]};

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: if (req_valid) w_next = w_err ? RESP : ACC0;
         ACC0: begin
            if (r_split)   w_next = ACC1;
            else if (r_we) w_next = RESP;
            else           w_next = CAP;
         end
         ACC1:    w_next = r_we ? RESP : CAP;
         CAP:     w_next = RESP;
         RESP:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      req_ready  = (r_state == IDLE);
      resp_valid = (r_state == RESP);
      mem_re     = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_be     = '0;
      mem_wdata  = '0;
      case (r_state)
         ACC0: begin
            mem_re   = !r_we;
            mem_we   = r_we;
            mem_addr = r_waddr;
            if (r_we) begin
               mem_be    = w_mask8[3:0];
               mem_wdata = w_wdata64[XLEN-1:0];
            end
         end
         ACC1: begin
            mem_re   = !r_we;
            mem_we   = r_we;
            mem_addr = r_waddr + MEM_AW'(1);
            if (r_we) begin
               mem_be    = w_mask8[7:4];
               mem_wdata = w_wdata64[2*XLEN-1:XLEN];
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_we    <= 1'b0;
         r_f3    <= '0;
         r_off   <= '0;
         r_split <= 1'b0;
         r_waddr <= '0;
         r_wdata <= '0;
         r_word0 <= '0;
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_we    <= req_we;
            r_f3    <= req_funct3;
            r_off   <= w_off;
            r_split <= w_split;
            r_waddr <= req_addr[MEM_AW+1:2];
            r_wdata <= req_wdata;
         end
         if (r_state == ACC1) r_word0 <= mem_rdata;
         // Only the IDLE->RESP path is an error; stores report zero data.
         if (w_next == RESP) begin
            r_err   <= (r_state == IDLE);
            r_rdata <= (r_state == CAP) ? w_ext : '0;
         end
      end
   end

   assign resp_rdata = r_rdata;
   assign resp_err   = r_err;

endmodule

// File: tb/tb_lsu_align.sv
`timescale 1ns/1ps
// tb_lsu_align: directed scoreboard bench for lsu_align with a byte-enable memory model.
module tb_lsu_align;
   localparam int MEM_AW = 11;

   logic        CLK = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_err;
   logic [31:0] resp_rdata;
   logic        mem_re, mem_we;
   logic [MEM_AW-1:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata, mem_rdata;

   lsu_align #(.MEM_AW(MEM_AW), .XLEN(32)) dut (
      .CLK(CLK), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_err(resp_err), .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          nrd;
      int          nwr;
      int          acc;
      int          rd0;
      int          wr0;
   } exp_t;

   exp_t  q[$];
   string cur_tag;
   int    n_checks = 0, n_errors = 0;
   int    cyc = 0, n_rd = 0, n_wr = 0, n_both = 0, n_resp = 0, n_iss = 0;
   logic [31:0] last_rd_addr = '0;

   logic [31:0] mem [0:2047];
   logic        pl_en = 1'b0;
   logic [10:0] pl_addr = '0;
   logic [31:0] pl_data = '0;
   logic [31:0] bm;

   assign bm = {{8{mem_be[3]}}, {8{mem_be[2]}}, {8{mem_be[1]}}, {8{mem_be[0]}}};

   always @(posedge CLK) begin
      cyc <= cyc + 1;
      if (mem_re) mem_rdata <= mem[mem_addr];
      if (mem_we) mem[mem_addr] <= (mem[mem_addr] & ~bm) | (mem_wdata & bm);
      if (pl_en)  mem[pl_addr] <= pl_data;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Response monitor: counts strobes and pops the scoreboard on each response.
   initial begin
      exp_t e;
      forever begin
         @(negedge CLK);
         if (mem_re) begin n_rd++; last_rd_addr = 32'(mem_addr); end
         if (mem_we) n_wr++;
         if (mem_re && mem_we) n_both++;
         if (resp_valid) begin
            n_resp++;
            check({cur_tag, "/pending"}, 32'(q.size()), 32'd1);
            if (q.size() > 0) begin
               e = q.pop_front();
               check({cur_tag, "/rdata"}, resp_rdata, e.rdata);
               check({cur_tag, "/err"}, 32'(resp_err), 32'(e.err));
               check({cur_tag, "/latency"}, 32'(cyc - e.acc + 1), 32'(e.lat));
               check({cur_tag, "/reads"}, 32'(n_rd - e.rd0), 32'(e.nrd));
               check({cur_tag, "/writes"}, 32'(n_wr - e.wr0), 32'(e.nwr));
            end
         end
      end
   end

   task automatic preload(input logic [10:0] a, input logic [31:0] d);
      pl_addr = a; pl_data = d; pl_en = 1'b1;
      @(posedge CLK); #1;
      pl_en = 1'b0;
   endtask

   // Drives one request at posedge+1 and returns at posedge+1 of cycle 1.
   task automatic issue(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] e_rdata, input logic e_err, input int e_lat,
                        input int e_nrd, input int e_nwr, input bit track);
      exp_t e;
      cur_tag = tag;
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
      check({tag, "/ready"}, 32'(req_ready), 32'd1);
      @(posedge CLK); #1;
      req_valid = 1'b0;
      e.rdata = e_rdata; e.err = e_err; e.lat = e_lat; e.nrd = e_nrd; e.nwr = e_nwr;
      e.acc = cyc; e.rd0 = n_rd; e.wr0 = n_wr;
      if (track) begin q.push_back(e); n_iss++; end
   endtask

   task automatic wait_resp(input string tag);
      for (int i = 0; i < 12; i++) begin
         @(posedge CLK); #1;
         if (q.size() == 0) break;
      end
      check({tag, "/timeout"}, 32'(q.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
      req_addr = '0; req_wdata = '0;
      #1 reset = 1'b1;
      #1;
      check("rst/req_ready", 32'(req_ready), 32'd1);
      check("rst/resp_valid", 32'(resp_valid), 32'd0);
      check("rst/resp_rdata", resp_rdata, 32'd0);
      check("rst/resp_err", 32'(resp_err), 32'd0);
      check("rst/mem_re", 32'(mem_re), 32'd0);
      check("rst/mem_we", 32'(mem_we), 32'd0);
      check("rst/mem_be", 32'(mem_be), 32'd0);
      check("rst/mem_addr", 32'(mem_addr), 32'd0);
      check("rst/mem_wdata", mem_wdata, 32'd0);
      @(posedge CLK); #1;
      reset = 1'b0;

      preload(11'h040, 32'h0080_0000);
      preload(11'h001, 32'hBEEF_1234);
      preload(11'h002, 32'h1234_5678);
      preload(11'h003, 32'h9A00_0000);
      preload(11'h008, 32'hAAAA_AAAA);
      preload(11'h009, 32'h0000_0000);
      preload(11'h7FF, 32'h11AA_BBCC);
      preload(11'h000, 32'h0044_3322);
      preload(11'h010, 32'h00AB_CD00);
      preload(11'h00C, 32'h0000_0000);

      issue("LB_102", 1'b0, 3'b000, 32'h102, 32'h0, 32'hFFFF_FF80, 1'b0, 3, 1, 0, 1'b1);
      check("LB_102/mem_re", 32'(mem_re), 32'd1);
      check("LB_102/mem_addr", 32'(mem_addr), 32'h40);
      check("LB_102/mem_we", 32'(mem_we), 32'd0);
      wait_resp("LB_102");

      issue("LHU_6", 1'b0, 3'b101, 32'h6, 32'h0, 32'h0000_BEEF, 1'b0, 3, 1, 0, 1'b1);
      wait_resp("LHU_6");
      issue("LH_6", 1'b0, 3'b001, 32'h6, 32'h0, 32'hFFFF_BEEF, 1'b0, 3, 1, 0, 1'b1);
      wait_resp("LH_6");
      repeat (2) @(posedge CLK);
      #1;
      check("LH_6/held_rdata", resp_rdata, 32'hFFFF_BEEF);
      check("LH_6/held_valid", 32'(resp_valid), 32'd0);

      issue("LW_8", 1'b0, 3'b010, 32'h8, 32'h0, 32'h1234_5678, 1'b0, 3, 1, 0, 1'b1);
      wait_resp("LW_8");
      issue("LBU_F", 1'b0, 3'b100, 32'hF, 32'h0, 32'h0000_009A, 1'b0, 3, 1, 0, 1'b1);
      wait_resp("LBU_F");
      issue("LB_F", 1'b0, 3'b000, 32'hF, 32'h0, 32'hFFFF_FF9A, 1'b0, 3, 1, 0, 1'b1);
      wait_resp("LB_F");

      issue("SB_21", 1'b1, 3'b000, 32'h21, 32'h1122_3344, 32'h0, 1'b0, 2, 0, 1, 1'b1);
      check("SB_21/mem_we", 32'(mem_we), 32'd1);
      check("SB_21/mem_addr", 32'(mem_addr), 32'h8);
      check("SB_21/mem_be", 32'(mem_be), 32'b0010);
      check("SB_21/mem_wdata", mem_wdata, 32'h2233_4400);
      wait_resp("SB_21");
      check("SB_21/mem8", mem[8], 32'hAAAA_44AA);

      issue("SH_26", 1'b1, 3'b001, 32'h26, 32'h1234_BEEF, 32'h0, 1'b0, 2, 0, 1, 1'b1);
      check("SH_26/mem_be", 32'(mem_be), 32'b1100);
      wait_resp("SH_26");
      check("SH_26/mem9", mem[9], 32'hBEEF_0000);

`ifdef LSU_MISALIGN_SPLIT_EN
      issue("SW_7", 1'b1, 3'b010, 32'h7, 32'hAABB_CCDD, 32'h0, 1'b0, 3, 0, 2, 1'b1);
      check("SW_7/c1_addr", 32'(mem_addr), 32'h1);
      check("SW_7/c1_be", 32'(mem_be), 32'b1000);
      check("SW_7/c1_wdata", mem_wdata, 32'hDD00_0000);
      @(posedge CLK); #1;
      check("SW_7/c2_addr", 32'(mem_addr), 32'h2);
      check("SW_7/c2_be", 32'(mem_be), 32'b0111);
      check("SW_7/c2_wdata", mem_wdata, 32'h00AA_BBCC);
      wait_resp("SW_7");
      check("SW_7/mem1", mem[1], 32'hDDEF_1234);
      check("SW_7/mem2", mem[2], 32'h12AA_BBCC);

      issue("LW_1FFF", 1'b0, 3'b010, 32'h1FFF, 32'h0, 32'h4433_2211, 1'b0, 4, 2, 0, 1'b1);
      wait_resp("LW_1FFF");
      check("LW_1FFF/wrap_addr", last_rd_addr, 32'h0);

      issue("LH_41", 1'b0, 3'b001, 32'h41, 32'h0, 32'hFFFF_ABCD, 1'b0, 3, 1, 0, 1'b1);
      wait_resp("LH_41");
`else
      issue("SW_7", 1'b1, 3'b010, 32'h7, 32'hAABB_CCDD, 32'h0, 1'b1, 1, 0, 0, 1'b1);
      check("SW_7/no_we", 32'(mem_we), 32'd0);
      wait_resp("SW_7");
      check("SW_7/mem1", mem[1], 32'hBEEF_1234);

      issue("LW_1FFF", 1'b0, 3'b010, 32'h1FFF, 32'h0, 32'h0, 1'b1, 1, 0, 0, 1'b1);
      wait_resp("LW_1FFF");

      issue("LH_41", 1'b0, 3'b001, 32'h41, 32'h0, 32'h0, 1'b1, 1, 0, 0, 1'b1);
      wait_resp("LH_41");
`endif

      issue("S_f3_100", 1'b1, 3'b100, 32'h40, 32'h1234_5678, 32'h0, 1'b1, 1, 0, 0, 1'b1);
      wait_resp("S_f3_100");
      @(posedge CLK); #1;
      check("S_f3_100/held_err", 32'(resp_err), 32'd1);
      issue("L_f3_011", 1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 1'b1, 1, 0, 0, 1'b1);
      wait_resp("L_f3_011");

`ifdef LSU_MISALIGN_SPLIT_EN
      issue("ABORT", 1'b0, 3'b010, 32'h1FFF, 32'h0, 32'h0, 1'b0, 0, 0, 0, 1'b0);
      @(posedge CLK); #1;
      check("ABORT/acc1_re", 32'(mem_re), 32'd1);
      check("ABORT/acc1_addr", 32'(mem_addr), 32'h0);
`else
      issue("ABORT", 1'b0, 3'b010, 32'h8, 32'h0, 32'h0, 1'b0, 0, 0, 0, 1'b0);
      check("ABORT/acc0_re", 32'(mem_re), 32'd1);
`endif
      #2 reset = 1'b1;
      #1;
      check("ABORT/re_drop", 32'(mem_re), 32'd0);
      @(posedge CLK); #1;
      reset = 1'b0;
      repeat (4) @(posedge CLK);
      #1;
      check("ABORT/ready", 32'(req_ready), 32'd1);
      check("ABORT/rdata_clr", resp_rdata, 32'd0);

      issue("SB_30", 1'b1, 3'b000, 32'h30, 32'h0000_005A, 32'h0, 1'b0, 2, 0, 1, 1'b1);
      wait_resp("SB_30");
      check("SB_30/memC", mem[12], 32'h0000_005A);

      check("no_re_we_overlap", 32'(n_both), 32'd0);
      check("resp_count", 32'(n_resp), 32'(n_iss));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
